sdram_pattern_tester: RTL and testbench
=======================================

SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clock and reset.
REQ-002 Parameter ADDR_W, default 29, SHALL set the word address width in DATA_W-bit units.
REQ-003 Parameter DATA_W, default 64, SHALL set the data width, which must be a multiple of 32.
REQ-004 Parameter BURST_LEN, default 8, SHALL set the maximum beats per burst (1..255).
REQ-005 Parameter SEED, default 32'h2357_1113, SHALL be XORed into the test pattern.
REQ-006 The ports SHALL be (name, direction, width, meaning):
- clock, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle run request.
- base_address, in, ADDR_W, first word of the test region.
- word_count, in, ADDR_W, number of words to test.
- busy, out, 1, run in progress.
- done, out, 1, sticky run-complete flag.
- pass, out, 1, done with zero mismatches.
- error_count, out, 16, mismatch count, saturating.
- first_error_address, out, ADDR_W, address of the first mismatch.
- address, out, ADDR_W, Avalon address.
- burstcount, out, 8, Avalon burst length.
- waitrequest, in, 1, Avalon stall.
- read, out, 1, Avalon read request.
- readdata, in, DATA_W, Avalon read data.
- readdatavalid, in, 1, Avalon read-data strobe.
- write, out, 1, Avalon write request.
- writedata, out, DATA_W, Avalon write data.
- byteenable, out, DATA_W/8, held all-ones.

Function
REQ-007 The pattern for word index i SHALL be (i[31:0] XOR SEED) replicated DATA_W/32 times.
REQ-008 The FSM states SHALL be IDLE, WR_BURST, RD_REQ, RD_DATA and DONE.
REQ-009 In IDLE and DONE, start=1 SHALL latch base_address and word_count, clear done, pass, error_count and first_error_address, and enter WR_BURST, with write=1 on the next cycle.
REQ-010 start=1 while busy SHALL be ignored.
REQ-011 word_count=0 SHALL go directly to DONE one cycle after start, with pass=1.
REQ-012 Each burst SHALL use burstcount = min(BURST_LEN, remaining words); address SHALL be the first word of the burst and SHALL stay constant for the whole burst.
REQ-013 In WR_BURST, a beat SHALL be accepted only on a cycle where write=1 and waitrequest=0; writedata SHALL then advance to the next index's pattern.
REQ-014 While waitrequest=1, write, writedata, address and burstcount SHALL all be held.
REQ-015 After the last write beat, the FSM SHALL return to the write region start and enter RD_REQ.
REQ-016 In RD_REQ, read=1 SHALL be held until waitrequest=0; read SHALL then deassert and the FSM SHALL enter RD_DATA.
REQ-017 In RD_DATA, each readdatavalid beat SHALL be compared with the expected pattern for its index.
REQ-018 On a mismatch, error_count SHALL increment, saturating at 16'hFFFF.
REQ-019 first_error_address SHALL capture only the first mismatch of a run.
REQ-020 After burstcount beats, RD_DATA SHALL issue the next RD_REQ; after the final beat it SHALL enter DONE.
REQ-021 Entering DONE SHALL set done=1 and pass=(error_count==0); done SHALL remain set until the next start.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDR_W; a region crossing the top of the address space SHALL continue from 0.
REQ-023 Only one read burst SHALL be outstanding at a time.
REQ-024 busy SHALL be 1 in WR_BURST, RD_REQ and RD_DATA, and 0 otherwise.
REQ-025 readdatavalid outside RD_DATA SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, and SHALL clear address, burstcount, read, write, writedata, busy, done, pass, error_count and first_error_address to 0.
REQ-027 Reset asserted mid-burst SHALL deassert read and write on the next clock edge, regardless of waitrequest.

Structure
REQ-028 The FSM state encoding and the pattern function SHALL reside in the shared package sdram_test_pkg.
REQ-029 The pattern generation SHALL be the sub-module sdram_pattern_gen (index in, DATA_W pattern out), instantiated once for writedata and once for the read-compare expected value.

Verification
REQ-030 Zero-wait slave, base=0x0700_0000, count=8, BURST_LEN=8: expect one 8-beat write burst, then one 8-beat read burst, done=1, pass=1, error_count=0.
REQ-031 count=19, BURST_LEN=8: expect write and read burstcounts of 8, 8, 3, with addresses base, base+8 and base+16.
REQ-032 Slave asserting waitrequest for 3 cycles on every beat: expect outputs held stable during the stall, no beats dropped, pass=1.
REQ-033 Slave corrupting the word at base+5 and base+9, count=16: expect error_count=2, first_error_address=base+5, pass=0.
REQ-034 base=29'h1FFF_FFFE, count=4: expect accesses to 1FFF_FFFE, 1FFF_FFFF, 0 and 1, and pass=1.
REQ-035 Reset asserted during the 3rd write beat: expect write=0 on the next cycle, IDLE, all outputs 0, and a following start running cleanly.

Source files
------------

// File: rtl/sdram_test_pkg.sv
// sdram_test_pkg
//   Shared definitions for the SDRAM pattern tester.
//   - ST_* : FSM state encoding used by sdram_pattern_tester
//   - pattern_word : 32-bit test word for a given region-relative word index
package sdram_test_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_BURST = 3'd1;
  localparam logic [2:0] ST_RD_REQ   = 3'd2;
  localparam logic [2:0] ST_RD_DATA  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  function automatic logic [31:0] pattern_word(input logic [31:0] idx,
                                               input logic [31:0] seed);
    return idx ^ seed;
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// sdram_pattern_gen
//   Combinational test-pattern generator: the 32-bit pattern word for the
//   given word index, replicated across the full data width.
//   Ports:
//     i_index   : in,  ADDR_W  word index relative to the start of the region
//     o_pattern : out, DATA_W  replicated pattern word
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int          ADDR_W = 29,
  parameter int          DATA_W = 64,
  parameter logic [31:0] SEED   = 32'h2357_1113
) (
  input  logic [ADDR_W-1:0] i_index,
  output logic [DATA_W-1:0] o_pattern
);

  logic [31:0] w_idx32;
  logic [31:0] w_word;

  // The pattern is defined on the low 32 bits of the index.
  generate
    if (ADDR_W >= 32) begin : g_trunc
      assign w_idx32 = i_index[31:0];
    end else begin : g_ext
      assign w_idx32 = {{(32-ADDR_W){1'b0}}, i_index};
    end
  endgenerate

  assign w_word = pattern_word(w_idx32, SEED);

  for (genvar gi = 0; gi < DATA_W/32; gi++) begin : g_rep
    assign o_pattern[gi*32 +: 32] = w_word;
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
//   Writes a deterministic pattern over a word region through an Avalon-MM
//   burst master, reads it back one burst at a time and counts mismatches.
//   Ports:
//     clock, reset           : clock, synchronous active-high reset
//     start                  : one-cycle run request (ignored while busy)
//     base_address/word_count: region to test (latched at start)
//     busy, done, pass       : run status (done sticky until next start)
//     error_count            : saturating mismatch count
//     first_error_address    : address of the first mismatch of the run
//     address .. byteenable  : Avalon-MM burst master interface
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int          ADDR_W    = 29,
  parameter int          DATA_W    = 64,
  parameter int          BURST_LEN = 8,
  parameter logic [31:0] SEED      = 32'h2357_1113
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_address,
  input  logic [ADDR_W-1:0]     word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [ADDR_W-1:0]     first_error_address,
  output logic [ADDR_W-1:0]     address,
  output logic [7:0]            burstcount,
  input  logic                  waitrequest,
  output logic                  read,
  input  logic [DATA_W-1:0]     readdata,
  input  logic                  readdatavalid,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_remaining;   // words not yet covered by an issued burst
  logic [ADDR_W-1:0] r_address;
  logic [7:0]        r_burstcount;
  logic [7:0]        r_beats_left;  // beats still owed in the current burst
  logic [ADDR_W-1:0] r_wr_idx;
  logic [ADDR_W-1:0] r_rd_idx;
  logic              r_read;
  logic              r_write;
  logic              r_done;
  logic              r_pass;
  logic [15:0]       r_error_count;
  logic [ADDR_W-1:0] r_first_error_address;

  logic [DATA_W-1:0] w_wr_pattern;
  logic [DATA_W-1:0] w_rd_pattern;
  logic              w_mismatch;
  logic [7:0]        w_start_bc;
  logic [7:0]        w_rem_bc;
  logic [7:0]        w_count_bc;

  function automatic logic [7:0] burst_of(input logic [ADDR_W-1:0] words);
    if (words >= ADDR_W'(BURST_LEN)) return 8'(BURST_LEN);
    return 8'(words);
  endfunction

  assign w_start_bc = burst_of(word_count);
  assign w_rem_bc   = burst_of(r_remaining);
  assign w_count_bc = burst_of(r_count);

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
    .i_index   (r_wr_idx),
    .o_pattern (w_wr_pattern)
  );

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED)) u_rd_gen (
    .i_index   (r_rd_idx),
    .o_pattern (w_rd_pattern)
  );

  assign w_mismatch = (readdata != w_rd_pattern);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state               <= ST_IDLE;
      r_base                <= '0;
      r_count               <= '0;
      r_remaining           <= '0;
      r_address             <= '0;
      r_burstcount          <= '0;
      r_beats_left          <= '0;
      r_wr_idx              <= '0;
      r_rd_idx              <= '0;
      r_read                <= 1'b0;
      r_write               <= 1'b0;
      r_done                <= 1'b0;
      r_pass                <= 1'b0;
      r_error_count         <= '0;
      r_first_error_address <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_base                <= base_address;
            r_count               <= word_count;
            r_done                <= 1'b0;
            r_pass                <= 1'b0;
            r_error_count         <= '0;
            r_first_error_address <= '0;
            r_wr_idx              <= '0;
            r_rd_idx              <= '0;
            if (word_count == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state      <= ST_WR_BURST;
              r_write      <= 1'b1;
              r_address    <= base_address;
              r_burstcount <= w_start_bc;
              r_beats_left <= w_start_bc;
              r_remaining  <= word_count - ADDR_W'(w_start_bc);
            end
          end
        end

        ST_WR_BURST: begin
          // Everything on the bus holds while the slave stalls.
          if (!waitrequest) begin
            r_wr_idx     <= r_wr_idx + ADDR_W'(1);
            r_beats_left <= r_beats_left - 8'd1;
            if (r_beats_left == 8'd1) begin
              if (r_remaining == '0) begin
                // Whole region written: rewind to its start for read-back.
                r_state      <= ST_RD_REQ;
                r_write      <= 1'b0;
                r_read       <= 1'b1;
                r_address    <= r_base;
                r_burstcount <= w_count_bc;
                r_beats_left <= w_count_bc;
                r_remaining  <= r_count - ADDR_W'(w_count_bc);
              end else begin
                r_address    <= r_address + ADDR_W'(r_burstcount);
                r_burstcount <= w_rem_bc;
                r_beats_left <= w_rem_bc;
                r_remaining  <= r_remaining - ADDR_W'(w_rem_bc);
              end
            end
          end
        end

        ST_RD_REQ: begin
          if (!waitrequest) begin
            r_read  <= 1'b0;
            r_state <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (readdatavalid) begin
            r_rd_idx     <= r_rd_idx + ADDR_W'(1);
            r_beats_left <= r_beats_left - 8'd1;
            if (w_mismatch) begin
              if (r_error_count != 16'hFFFF) r_error_count <= r_error_count + 16'd1;
              // The count only leaves zero on the first mismatch of a run.
              if (r_error_count == 16'd0) r_first_error_address <= r_base + r_rd_idx;
            end
            if (r_beats_left == 8'd1) begin
              if (r_remaining == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_pass  <= (r_error_count == 16'd0) && !w_mismatch;
              end else begin
                r_state      <= ST_RD_REQ;
                r_read       <= 1'b1;
                r_address    <= r_address + ADDR_W'(r_burstcount);
                r_burstcount <= w_rem_bc;
                r_beats_left <= w_rem_bc;
                r_remaining  <= r_remaining - ADDR_W'(w_rem_bc);
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy                = (r_state == ST_WR_BURST) || (r_state == ST_RD_REQ) ||
                               (r_state == ST_RD_DATA);
  assign done                = r_done;
  assign pass                = r_pass;
  assign error_count         = r_error_count;
  assign first_error_address = r_first_error_address;
  assign address             = r_address;
  assign burstcount          = r_burstcount;
  assign read                = r_read;
  assign write               = r_write;
  assign writedata           = r_write ? w_wr_pattern : '0;
  assign byteenable          = '1;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
module tb_sdram_pattern_tester;

  localparam int          AW   = 29;
  localparam int          DW   = 64;
  localparam logic [31:0] SEED = 32'h2357_1113;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] word_count;
  logic          busy, done, pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_error_address;
  logic [AW-1:0] address;
  logic [7:0]    burstcount;
  logic          waitrequest   = 1'b0;
  logic          read;
  logic [DW-1:0] readdata      = '0;
  logic          readdatavalid = 1'b0;
  logic          write;
  logic [DW-1:0] writedata;
  logic [DW/8-1:0] byteenable;

  always #5 clock = ~clock;

  sdram_pattern_tester dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .base_address        (base_address),
    .word_count          (word_count),
    .busy                (busy),
    .done                (done),
    .pass                (pass),
    .error_count         (error_count),
    .first_error_address (first_error_address),
    .address             (address),
    .burstcount          (burstcount),
    .waitrequest         (waitrequest),
    .read                (read),
    .readdata            (readdata),
    .readdatavalid       (readdatavalid),
    .write               (write),
    .writedata           (writedata),
    .byteenable          (byteenable)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [AW-1:0] idx);
    logic [31:0] w;
    w = {3'b000, idx} ^ SEED;
    return {w, w};
  endfunction

  // ---------------- slave model / scoreboard ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    bc;
  } burst_t;

  burst_t        exp_wr_q[$];
  burst_t        exp_rd_q[$];
  logic [AW-1:0] rdq[$];
  logic [63:0]   mem [logic [AW-1:0]];

  bit            slave_en = 1'b0;
  bit            stall_mode = 1'b0;
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_a = '0, corrupt_b = '0;
  int            stall_cnt = 0;
  int            wr_left = 0;
  int            wr_beats = 0;
  logic [AW-1:0] wr_idx = '0;
  logic [AW-1:0] cur_addr = '0;
  logic [7:0]    cur_bc = '0;
  bit            prev_stall = 1'b0;
  bit            rv_toggle = 1'b0;
  logic [102:0]  prev_snap = '0;

  always @(negedge clock) begin
    logic [AW-1:0] a;
    burst_t        b;
    bit            acc;
    logic [102:0]  snap;

    // read-data return: at most one beat per cycle, gappy when stalling
    readdatavalid = 1'b0;
    readdata      = '0;
    if (slave_en && rdq.size() > 0 && (!stall_mode || rv_toggle)) begin
      a = rdq.pop_front();
      readdata = mem.exists(a) ? mem[a] : 64'h0;
      if (corrupt_en && (a == corrupt_a || a == corrupt_b)) readdata = readdata ^ 64'h1;
      readdatavalid = 1'b1;
    end
    rv_toggle = !rv_toggle;

    if (slave_en) begin
      snap = {write, read, address, burstcount, writedata};
      if (prev_stall) check("stall_hold", 128'(snap), 128'(prev_snap));
      acc = 1'b0;
      if ((write || read) && stall_mode && stall_cnt < 3) begin
        waitrequest = 1'b1;
        stall_cnt++;
        prev_stall = 1'b1;
        prev_snap  = snap;
      end else begin
        waitrequest = 1'b0;
        stall_cnt   = 0;
        prev_stall  = 1'b0;
        acc         = write || read;
      end

      if (acc && write) begin
        if (wr_left == 0) begin
          if (exp_wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected_burst actual=%0h required=none", address);
          end else begin
            b = exp_wr_q.pop_front();
            check("wr_burst_addr", 128'(address), 128'(b.addr));
            check("wr_burst_bc", 128'(burstcount), 128'(b.bc));
          end
          $display("WR burst addr=%07h bc=%0d", address, burstcount);
          cur_addr = address;
          cur_bc   = burstcount;
          wr_left  = int'(burstcount);
        end else begin
          check("wr_addr_const", 128'(address), 128'(cur_addr));
          check("wr_bc_const", 128'(burstcount), 128'(cur_bc));
        end
        check("wr_data", 128'(writedata), 128'(pat(wr_idx)));
        mem[cur_addr + AW'(int'(cur_bc) - wr_left)] = writedata;
        wr_idx = wr_idx + 1'b1;
        wr_left--;
        wr_beats++;
      end

      if (acc && read) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected_burst actual=%0h required=none", address);
        end else begin
          b = exp_rd_q.pop_front();
          check("rd_burst_addr", 128'(address), 128'(b.addr));
          check("rd_burst_bc", 128'(burstcount), 128'(b.bc));
        end
        $display("RD burst addr=%07h bc=%0d", address, burstcount);
        for (int k = 0; k < int'(burstcount); k++) rdq.push_back(address + AW'(k));
      end
    end else begin
      waitrequest = 1'b0;
      prev_stall  = 1'b0;
      stall_cnt   = 0;
    end
  end

  // ---------------- test table ----------------
  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] count;
    bit            stall;
    bit            corrupt;
    bit            poke;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_first;
    bit            exp_pass;
  } vec_t;

  vec_t vecs[7];

  task automatic prepare(input logic [AW-1:0] base, input logic [AW-1:0] count, input bit with_reads);
    logic [AW-1:0] off;
    logic [AW-1:0] bc;
    burst_t        b;
    mem.delete();
    rdq.delete();
    exp_wr_q.delete();
    exp_rd_q.delete();
    wr_left  = 0;
    wr_beats = 0;
    wr_idx   = '0;
    off = '0;
    while (off < count) begin
      bc = ((count - off) >= AW'(8)) ? AW'(8) : (count - off);
      b.addr = base + off;
      b.bc   = 8'(bc);
      exp_wr_q.push_back(b);
      if (with_reads) exp_rd_q.push_back(b);
      off = off + bc;
    end
  endtask

  task automatic run_test(input int n, input vec_t t);
    int cyc;
    prepare(t.base, t.count, 1'b1);
    stall_mode = t.stall;
    corrupt_en = t.corrupt;
    corrupt_a  = t.base + AW'(5);
    corrupt_b  = t.base + AW'(9);

    base_address = t.base;
    word_count   = t.count;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (t.count == '0) begin
      check("zero_done", 128'(done), 128'(1));
      check("zero_pass", 128'(pass), 128'(1));
      check("zero_busy", 128'(busy), 128'(0));
    end else begin
      check("start_busy", 128'(busy), 128'(1));
      check("start_write", 128'(write), 128'(1));
      check("start_done_clr", 128'(done), 128'(0));
    end

    if (t.poke) begin
      repeat (5) @(posedge clock);
      #1;
      base_address = 29'h0000_0555;
      word_count   = 29'd3;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("poke_still_busy", 128'(busy), 128'(1));
    end

    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("done_reached", 128'(done), 128'(1));
    check("pass", 128'(pass), 128'(t.exp_pass));
    check("error_count", 128'(error_count), 128'(t.exp_err));
    check("first_error_address", 128'(first_error_address), 128'(t.exp_first));
    check("end_busy", 128'(busy), 128'(0));
    check("end_rw", 128'({read, write}), 128'(0));
    check("wr_beats", 128'(wr_beats), 128'(t.count));
    check("wr_bursts_left", 128'(exp_wr_q.size()), 128'(0));
    check("rd_bursts_left", 128'(exp_rd_q.size()), 128'(0));
    check("rd_beats_left", 128'(rdq.size()), 128'(0));
    $display("TEST %0d base=%07h count=%0d errs=%0d pass=%0d", n, t.base, t.count, error_count, pass);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int cyc;
    vec_t v;

    reset = 1'b1;
    start = 1'b0;
    base_address = '0;
    word_count   = '0;

    vecs[0] = '{29'h0700_0000, 29'd8,  1'b0, 1'b0, 1'b0, 16'd0, 29'h0,         1'b1};
    vecs[1] = '{29'h0700_0000, 29'd19, 1'b0, 1'b0, 1'b0, 16'd0, 29'h0,         1'b1};
    vecs[2] = '{29'h0000_0100, 29'd10, 1'b1, 1'b0, 1'b1, 16'd0, 29'h0,         1'b1};
    vecs[3] = '{29'h0000_0200, 29'd16, 1'b0, 1'b1, 1'b0, 16'd2, 29'h0000_0205, 1'b0};
    vecs[4] = '{29'h1FFF_FFFE, 29'd4,  1'b0, 1'b0, 1'b0, 16'd0, 29'h0,         1'b1};
    vecs[5] = '{29'h0000_0000, 29'd0,  1'b0, 1'b0, 1'b0, 16'd0, 29'h0,         1'b1};
    vecs[6] = '{29'h0000_0040, 29'd1,  1'b1, 1'b0, 1'b0, 16'd0, 29'h0,         1'b1};

    repeat (3) @(posedge clock);
    #1;
    check("rst_address", 128'(address), 128'(0));
    check("rst_burstcount", 128'(burstcount), 128'(0));
    check("rst_rw", 128'({read, write}), 128'(0));
    check("rst_writedata", 128'(writedata), 128'(0));
    check("rst_status", 128'({busy, done, pass}), 128'(0));
    check("rst_error_count", 128'(error_count), 128'(0));
    check("rst_first_error", 128'(first_error_address), 128'(0));
    check("byteenable", 128'(byteenable), 128'(8'hFF));

    reset    = 1'b0;
    slave_en = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) run_test(i, vecs[i]);

    // Reset while the third write beat is on the bus.
    prepare(29'h0000_0300, 29'd8, 1'b0);
    stall_mode = 1'b0;
    corrupt_en = 1'b0;
    base_address = 29'h0000_0300;
    word_count   = 29'd8;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    while (wr_beats < 2 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("rst_mid_beats", 128'(wr_beats), 128'(2));
    check("rst_mid_write", 128'(write), 128'(1));
    check("rst_mid_data", 128'(writedata), 128'(pat(29'd2)));
    slave_en = 1'b0;
    reset    = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_write_off", 128'(write), 128'(0));
    check("rst_mid_read_off", 128'(read), 128'(0));
    check("rst_mid_outputs", 128'({busy, done, pass, address, burstcount}), 128'(0));
    check("rst_mid_err", 128'({error_count, first_error_address}), 128'(0));
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_idle", 128'({busy, write, read}), 128'(0));
    $display("TEST reset-mid-burst done");
    slave_en = 1'b1;
    v = '{29'h0000_0300, 29'd12, 1'b0, 1'b0, 1'b0, 16'd0, 29'h0, 1'b1};
    run_test(7, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
